// File: rtl/crypto_job_scheduler_pkg.sv
// Shared encodings for the crypto job scheduler: op codes, FSM states and
// the cipher block width.
package crypto_sched_pkg;

    localparam int BLOCK_W = 64;

    localparam logic OP_SPECK = 1'b0;
    localparam logic OP_RC4   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/crypto_job_scheduler_if.sv
// Request/response bundle between the two core-side requesters and the
// scheduler. The master is the core side, the slave is the scheduler.
interface crypto_job_scheduler_if;
    import crypto_sched_pkg::*;

    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_op;
    logic [2*BLOCK_W-1:0] req_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [BLOCK_W-1:0]   rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/crypto_job_scheduler_arb.sv
// Two-way round-robin arbiter. The last-grant pointer only moves when the
// grant is actually taken, so a grant offered while busy costs nothing.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_1,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last;  // 1 = requester 1 was granted most recently

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1)    last <= 1'b1;
        else if (accept) last <= grant[1];
    end
endmodule

// File: rtl/crypto_job_scheduler.sv
// Shares the Speck/RC4 datapath between two requesters: accepts one job,
// pulses the matching start, waits for done under a watchdog and returns a
// tagged response.
module crypto_job_scheduler
    import crypto_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_1,
    crypto_job_scheduler_if.slave bus,
    output logic                  start_speck,
    output logic                  start_rc4,
    output logic [BLOCK_W-1:0]    eng_din,
    input  logic                  eng_done,
    input  logic [BLOCK_W-1:0]    eng_dout,
    output logic                  busy
);
    localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    sched_state_e       state, state_nxt;
    logic [1:0]         grant;
    logic               accept;
    logic               id_q;
    logic               op_q;
    logic [BLOCK_W-1:0] blk_q;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               timeout;
    logic               rsp_id_q;
    logic [BLOCK_W-1:0] rsp_data_q;
    logic               rsp_err_q;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_1 (reset_1),
        .req     (bus.req_valid),
        .accept  (accept),
        .grant   (grant)
    );

    // Handshake and datapath-facing outputs decoded from the current state.
    // req_ready is also gated by reset so it drops the moment reset asserts.
    always_comb begin
        bus.req_ready = 2'b00;
        if (state == IDLE && reset_1) bus.req_ready = grant;
        accept        = |bus.req_ready;
        start_speck   = (state == ISSUE) && (op_q == OP_SPECK);
        start_rc4     = (state == ISSUE) && (op_q == OP_RC4);
        eng_din       = '0;
        if (state == ISSUE || state == WAIT) eng_din = blk_q;
        busy          = (state != IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_id    = rsp_id_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = rsp_err_q;
    end

    // Saturating watchdog step; the timeout fires on the WAIT cycle whose
    // increment reaches the limit.
    always_comb begin
        cnt_nxt = (cnt == TO_VAL) ? cnt : cnt + CNT_W'(1);
        timeout = (state == WAIT) && (cnt_nxt == TO_VAL);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state; done takes priority over the watchdog.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (eng_done || timeout) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job latch, watchdog counter and response capture.
    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            id_q       <= 1'b0;
            op_q       <= OP_SPECK;
            blk_q      <= '0;
            cnt        <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                id_q  <= grant[1];
                op_q  <= bus.req_op[grant[1]];
                blk_q <= grant[1] ? bus.req_data[2*BLOCK_W-1:BLOCK_W]
                                  : bus.req_data[BLOCK_W-1:0];
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt_nxt;
            if (state == WAIT && (eng_done || timeout)) begin
                rsp_id_q   <= id_q;
                rsp_data_q <= eng_done ? eng_dout : '0;
                rsp_err_q  <= !eng_done;
            end
        end
    end
endmodule

// File: tb/tb_crypto_job_scheduler.sv
// Directed bench for crypto_job_scheduler: instance a uses the default
// watchdog, instance b a watchdog of 8 cycles.
module tb_crypto_job_scheduler;
    logic clk;
    logic rst_a, rst_b;
    logic start_speck_a, start_rc4_a, busy_a, done_a;
    logic [63:0] din_a, dout_a;
    logic start_speck_b, start_rc4_b, busy_b, done_b;
    logic [63:0] din_b, dout_b;
    int checks = 0;
    int errors = 0;

    crypto_job_scheduler_if aif ();
    crypto_job_scheduler_if bif ();

    crypto_job_scheduler dut_a (
        .clk(clk), .reset_1(rst_a), .bus(aif),
        .start_speck(start_speck_a), .start_rc4(start_rc4_a),
        .eng_din(din_a), .eng_done(done_a), .eng_dout(dout_a), .busy(busy_a)
    );

    crypto_job_scheduler #(.TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .reset_1(rst_b), .bus(bif),
        .start_speck(start_speck_b), .start_rc4(start_rc4_b),
        .eng_din(din_b), .eng_done(done_b), .eng_dout(dout_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        done_a = 1'b0; dout_a = '0; done_b = 1'b0; dout_b = '0;
        aif.req_valid = 2'b00; aif.req_op = 2'b00; aif.req_data = '0; aif.rsp_ready = 1'b0;
        bif.req_valid = 2'b00; bif.req_op = 2'b00; bif.req_data = '0; bif.rsp_ready = 1'b0;
        tick(); tick();
        // Reset state
        check("rst_busy", busy_a, 0);
        check("rst_rsp_valid", aif.rsp_valid, 0);
        check("rst_eng_din", din_a, 0);
        check("rst_rsp_data", aif.rsp_data, 0);
        rst_a = 1'b1; rst_b = 1'b1;

        // Contention: both valid, 4 jobs, done in first WAIT cycle
        aif.req_valid = 2'b11;
        aif.req_op    = 2'b10;
        aif.req_data  = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        aif.rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("cont_grant", aif.req_ready, (j % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("cont_start_rc4", start_rc4_a, j % 2);
            check("cont_din", din_a, (j % 2 == 0) ? 64'h5555_6666_7777_8888 : 64'h1111_2222_3333_4444);
            done_a = 1'b1; dout_a = 64'hA0 + 64'(j);
            tick();
            tick();
            check("cont_rsp_valid", aif.rsp_valid, 1);
            check("cont_rsp_id", aif.rsp_id, j % 2);
            check("cont_rsp_data", aif.rsp_data, 64'hA0 + 64'(j));
            check("cont_ready_resp", aif.req_ready, 0);
            done_a = 1'b0;
            tick();
        end
        aif.req_valid = 2'b00;
        aif.rsp_ready = 1'b0;

        // Single Speck job from requester 0, done 10 cycles after start
        aif.req_valid = 2'b01;
        aif.req_op    = 2'b00;
        aif.req_data  = {64'h0, 64'h0123_4567_89AB_CDEF};
        #1;
        check("speck_grant", aif.req_ready, 2'b01);
        tick();
        check("speck_start", start_speck_a, 1);
        check("speck_no_rc4", start_rc4_a, 0);
        check("speck_din", din_a, 64'h0123_4567_89AB_CDEF);
        aif.req_valid = 2'b00;
        tick();
        check("speck_start_once", start_speck_a, 0);
        check("speck_din_wait", din_a, 64'h0123_4567_89AB_CDEF);
        for (int k = 3; k <= 11; k++) tick();
        check("speck_no_early_rsp", aif.rsp_valid, 0);
        done_a = 1'b1; dout_a = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        check("speck_rsp_valid", aif.rsp_valid, 1);
        check("speck_rsp_id", aif.rsp_id, 0);
        check("speck_rsp_err", aif.rsp_err, 0);
        check("speck_rsp_data", aif.rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
        check("speck_din_resp", din_a, 0);
        done_a = 1'b0;
        // Backpressure with a stray done pulse in RESP
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin done_a = 1'b1; dout_a = 64'hFFFF_FFFF_FFFF_FFFF; end
            tick();
            done_a = 1'b0;
            check("bp_rsp_valid", aif.rsp_valid, 1);
            check("bp_rsp_data", aif.rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
            check("bp_rsp_err", aif.rsp_err, 0);
        end
        aif.rsp_ready = 1'b1;
        tick();
        check("bp_done_valid", aif.rsp_valid, 0);
        check("bp_done_busy", busy_a, 0);
        aif.rsp_ready = 1'b0;

        // Timeout: RC4 job on requester 1, watchdog of 8
        bif.req_valid = 2'b10;
        bif.req_op    = 2'b10;
        bif.req_data  = {64'h0BAD_F00D_1234_5678, 64'h0};
        #1;
        check("to_grant", bif.req_ready, 2'b10);
        tick();
        check("to_start_rc4", start_rc4_b, 1);
        check("to_no_speck", start_speck_b, 0);
        bif.req_valid = 2'b00;
        for (int k = 2; k <= 9; k++) tick();
        check("to_not_yet", bif.rsp_valid, 0);
        tick();
        check("to_rsp_valid", bif.rsp_valid, 1);
        check("to_rsp_err", bif.rsp_err, 1);
        check("to_rsp_data", bif.rsp_data, 0);
        check("to_rsp_id", bif.rsp_id, 1);
        bif.rsp_ready = 1'b1;
        tick();
        check("to_idle", busy_b, 0);

        // Done/timeout collision: done in the cycle the watchdog expires
        bif.req_valid = 2'b01;
        bif.req_op    = 2'b00;
        bif.req_data  = {64'h0, 64'h7777_0000_7777_0000};
        #1;
        check("col_grant", bif.req_ready, 2'b01);
        tick();
        bif.req_valid = 2'b00;
        for (int k = 2; k <= 9; k++) tick();
        check("col_not_yet", bif.rsp_valid, 0);
        done_b = 1'b1; dout_b = 64'h1357_9BDF_2468_ACE0;
        tick();
        done_b = 1'b0;
        check("col_rsp_valid", bif.rsp_valid, 1);
        check("col_rsp_err", bif.rsp_err, 0);
        check("col_rsp_data", bif.rsp_data, 64'h1357_9BDF_2468_ACE0);
        tick();
        check("col_idle", busy_b, 0);
        bif.rsp_ready = 1'b0;

        // Reset three cycles into WAIT
        aif.req_valid = 2'b01;
        aif.req_op    = 2'b00;
        aif.req_data  = {64'h0, 64'hCAFE_0000_BEEF_0000};
        #1;
        check("rstw_grant", aif.req_ready, 2'b01);
        tick();
        aif.req_valid = 2'b00;
        tick(); tick(); tick();
        check("rstw_busy_before", busy_a, 1);
        aif.req_valid = 2'b11;
        #1;
        rst_a = 1'b0;
        #1;
        check("rstw_busy", busy_a, 0);
        check("rstw_din", din_a, 0);
        check("rstw_ready", aif.req_ready, 0);
        check("rstw_rsp_valid", aif.rsp_valid, 0);
        check("rstw_rsp_data", aif.rsp_data, 0);
        check("rstw_starts", {start_speck_a, start_rc4_a}, 0);
        aif.req_valid = 2'b00;
        tick();
        rst_a = 1'b1;
        aif.rsp_ready = 1'b1;
        tick();
        done_a = 1'b1; dout_a = 64'h1;
        tick();
        done_a = 1'b0;
        tick(); tick();
        check("rstw_no_rsp", aif.rsp_valid, 0);
        check("rstw_idle", busy_a, 0);
        aif.req_valid = 2'b11;
        #1;
        check("rstw_tie_grant", aif.req_ready, 2'b01);
        aif.req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
